noc_inject_arbiter: RTL

Shares the single NoC injection port between `NUM_REQ` packet sources (PCI scheduler, local PE traffic generators) using round-robin arbitration with a registered output stage. Tracks packets in flight against the reorder-buffer depth on the return path, and stalls injection when every slot is in use. Sits between the request sources and the NoC injection interface (`o_valid`/`o_data`/`i_ready`), and observes the NoC return write strobe.

---
 rtl/noc_inject_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter for the NoC port, with a one-deep registered output
// stage and an outstanding-packet credit counter sized to the return reorder buffer.
module noc_inject_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 265,
    parameter int MAX_OUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_valid,
    output logic [DATA_W-1:0]             o_data,
    input  logic                          i_ready,
    input  logic                          i_ret,
    output logic [CNT_W-1:0]              o_outstanding,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ID_W-1:0]   gid_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic              err_r;

    logic              arb_en_s;
    logic              found_s;
    logic              accept_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [ID_W-1:0]   rr_next_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [DATA_W-1:0] sel_data_s;

    // Credits are judged on the registered count only, so i_ret never reaches o_req_ready.
    assign arb_en_s = reset_n && (!valid_r || i_ready) && (cnt_r < CNT_W'(MAX_OUT));

    // Round-robin search from rr_ptr_r, ascending with wrap.
    always_comb begin : rr_search
        int idx;
        idx        = 0;
        found_s    = 1'b0;
        grant_id_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && i_req_valid[ID_W'(idx)]) begin
                found_s    = 1'b1;
                grant_id_s = ID_W'(idx);
            end else begin
                found_s    = found_s;
            end
        end
    end

    // One-hot grant and the matching packet mux.
    always_comb begin
        grant_s    = '0;
        sel_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_s == ID_W'(k)) begin
                sel_data_s = i_req_data[k*DATA_W +: DATA_W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        if (arb_en_s && found_s) begin
            grant_s[grant_id_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign accept_s  = arb_en_s && found_s;
    assign rr_next_s = (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r  <= 1'b0;
            data_r   <= '0;
            gid_r    <= '0;
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            valid_r  <= 1'b1;
            data_r   <= sel_data_s;
            gid_r    <= grant_id_s;
            rr_ptr_r <= rr_next_s;
        end else if (i_ready) begin
            valid_r  <= 1'b0;
        end else begin
            valid_r  <= valid_r;
        end
    end

    // Outstanding counter; a return against an empty count is an underflow and sticks in err_r.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            case ({accept_s, i_ret})
                2'b10: cnt_r <= cnt_r + CNT_W'(1);
                2'b01: begin
                    if (cnt_r == CNT_W'(0)) begin
                        err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                2'b11: begin
                    if (cnt_r == CNT_W'(0)) begin
                        cnt_r <= CNT_W'(1);
                        err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign o_req_ready   = grant_s;
    assign o_valid       = valid_r;
    assign o_data        = data_r;
    assign o_outstanding = cnt_r;
    assign o_grant_id    = gid_r;
    assign o_err         = err_r;

endmodule
